key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Conditions the raw active-low push-buttons (hour set, minute set, run/set) before they reach the clock counter and display stage.
- Synchronises, debounces and classifies each key.
- Emits a stable level plus single-cycle press, release and auto-repeat pulses in the clk domain.
- Downstream counters step on pulses, so they no longer need to derive clock edges from key levels.

Parameters:
- N_KEYS, 3, number of independent key channels (bit 0 = minute, 1 = hour, 2 = enable).
- DEBOUNCE_CYCLES, 8192, consecutive stable clk cycles required to accept a level change.
- REPEAT_DELAY, 25000000, clk cycles a key must stay held after the accepted press before the first repeat pulse.
- REPEAT_PERIOD, 5000000, clk cycles between subsequent repeat pulses.
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- key_n  input  N_KEYS  raw buttons, active-low, asynchronous to clk
- key_level  output  N_KEYS  debounced state, 1 = held
- key_press  output  N_KEYS  1-cycle pulse on accepted press
- key_release  output  N_KEYS  1-cycle pulse on accepted release
- key_repeat  output  N_KEYS  1-cycle pulse per auto-repeat tick while held

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - all outputs 0
  - synchroniser flops 1 (released)
  - all counters 0
  - every channel FSM in IDLE
- Synchroniser: each key_n bit passes through 2 flops and is inverted. Internal s[i] = 1 means pressed. Input-to-s latency is 2 cycles.
- Per-channel FSM, channels fully independent, one debounce counter and one repeat counter each:
  - IDLE: key_level = 0. If s = 1, clear the counter and go to DB_PRESS.
  - DB_PRESS:
    - If s = 0, return to IDLE (bounce rejected, no pulse).
    - Otherwise increment the counter. When count reaches DEBOUNCE_CYCLES-1, go to HELD, set key_level = 1, pulse key_press for 1 cycle and clear the repeat counter.
  - HELD:
    - If s = 0, clear the counter and go to DB_RELEASE.
    - Otherwise increment the repeat counter. At REPEAT_DELAY-1, pulse key_repeat, clear the counter and go to REPEAT.
  - REPEAT:
    - If s = 0, go to DB_RELEASE.
    - Otherwise increment the counter. At REPEAT_PERIOD-1, pulse key_repeat and clear the counter.
  - DB_RELEASE:
    - If s = 1, return to HELD; the repeat counter restarts at 0 and no pulse is emitted.
    - Otherwise increment the counter. At DEBOUNCE_CYCLES-1, go to IDLE, set key_level = 0 and pulse key_release.
- Latency: an accepted press pulse appears exactly 2 + DEBOUNCE_CYCLES cycles after a clean falling edge on key_n. Release latency is the same.
- Pulse exclusivity: within one channel, key_press, key_repeat and key_release are mutually exclusive in any cycle. Pulses are never wider than 1 cycle.
- Simultaneous keys: channels are independent, so pulses on different channels may coincide in the same cycle.
- Counters saturate, never wrap. A counter is cleared on every state change.
- Reset mid-operation forces the state to IDLE immediately. A held key must then re-debounce and produce a fresh key_press after rst deasserts.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined: HELD and REPEAT states behave as described above.
- Undefined:
  - HELD never times out, and the REPEAT state and repeat counters are not built.
  - key_repeat is tied to 0.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
- Reset: assert rst = 0 with key_n = 0 → all outputs 0. Deassert; with DEBOUNCE_CYCLES = 8 → key_press[i] = 1 exactly 10 cycles later, key_level = 1 thereafter.
- Bounce rejection (DEBOUNCE_CYCLES = 8): toggle key_n[0] low for 5 cycles, high for 3, low for 6, then high → no key_press, key_level stays 0.
- Clean press/release (DEBOUNCE_CYCLES = 8): key_n[1] low for 30 cycles then high → key_press at cycle 10, key_release 10 cycles after the rising edge, exactly one of each.
- Auto-repeat (DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 5, KEY_AUTO_REPEAT_EN defined): hold key_n[0] low for 60 cycles → key_press at 6, key_repeat at 26, 31, 36, … while held. Without the macro → key_repeat never asserts.
- Independence: press key 0 and key 2 on the same cycle → key_press = 3'b101 in one cycle. Release key 2 only → key_release = 3'b100 while key_level[0] stays 1.
- Reset mid-hold: assert rst for 1 cycle during REPEAT → outputs 0 immediately. After release of rst with the key still held → new key_press after 2 + DEBOUNCE_CYCLES cycles.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Key bus between the raw push-buttons and the key conditioner.
// master: button side (drives key_n, observes conditioned outputs).
// slave : key_conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (output key_n, input key_level, key_press, key_release, key_repeat);
  modport slave  (input key_n, output key_level, key_press, key_release, key_repeat);
endinterface

// File: rtl/key_conditioner.sv
// Key conditioner: 2-flop synchroniser, per-key debounce FSM, press/release
// pulses and optional auto-repeat pulses, all in the clk domain.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat; off by default,
// in which case key_repeat is tied low and no repeat logic is built).

// One key channel. s = synchronised key, 1 = pressed.
module key_chan #(
  parameter int DEBOUNCE_CYCLES = 8192,
`ifdef KEY_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
`endif
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DB_PRESS   = 3'd1;
  localparam logic [2:0] HELD       = 3'd2;
  localparam logic [2:0] DB_RELEASE = 3'd4;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // Debounce counter saturates instead of wrapping.
  assign db_inc = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + CNT_W'(1);

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [2:0] REPEAT = 3'd3;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d, rp_inc;
  logic             rpt_q, rpt_d;

  assign rp_inc = (rp_cnt_q == '1) ? rp_cnt_q : rp_cnt_q + CNT_W'(1);
`endif

  // Next-state logic. The debounce test looks at the incremented count so the
  // IDLE detection cycle counts as the first stable cycle (press lands 2+N
  // cycles after the key edge). The repeat test looks at the current count so
  // the first repeat lands exactly REPEAT_DELAY cycles after the press.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rp_cnt_d = rp_cnt_q;
    rpt_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s) begin
          db_cnt_d = '0;
          state_d  = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          db_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DB_LAST) begin
            db_cnt_d = '0;
            state_d  = HELD;
            level_d  = 1'b1;
            press_d  = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rp_cnt_d = '0;
`endif
          end
        end
      end
      HELD: begin
        if (!s) begin
          db_cnt_d = '0;
          state_d  = DB_RELEASE;
`ifdef KEY_AUTO_REPEAT_EN
          rp_cnt_d = '0;
        end else begin
          rp_cnt_d = rp_inc;
          if (rp_cnt_q == RD_LAST) begin
            rpt_d    = 1'b1;
            rp_cnt_d = '0;
            state_d  = REPEAT;
          end
`endif
        end
      end
`ifdef KEY_AUTO_REPEAT_EN
      REPEAT: begin
        if (!s) begin
          db_cnt_d = '0;
          rp_cnt_d = '0;
          state_d  = DB_RELEASE;
        end else begin
          rp_cnt_d = rp_inc;
          if (rp_cnt_q == RP_LAST) begin
            rpt_d    = 1'b1;
            rp_cnt_d = '0;
          end
        end
      end
`endif
      DB_RELEASE: begin
        if (s) begin
          // Bounce on release: back to HELD, repeat timing starts over.
          db_cnt_d = '0;
          state_d  = HELD;
`ifdef KEY_AUTO_REPEAT_EN
          rp_cnt_d = '0;
`endif
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DB_LAST) begin
            db_cnt_d = '0;
            state_d  = IDLE;
            level_d  = 1'b0;
            rel_d    = 1'b1;
          end
        end
      end
      default: begin
        db_cnt_d = '0;
        level_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Channel state and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  // Repeat counter and repeat pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_cnt_q <= '0;
      rpt_q    <= 1'b0;
    end else begin
      rp_cnt_q <= rp_cnt_d;
      rpt_q    <= rpt_d;
    end
  end
  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
endmodule

module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 8192,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  key_conditioner_if.slave kif
);
  // Elaboration guard: the counters must be able to hold every terminal count.
  if ((CNT_W < 32) &&
      (((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) ||
       ((64'd1 << CNT_W) < 64'(REPEAT_DELAY)) ||
       ((64'd1 << CNT_W) < 64'(REPEAT_PERIOD)))) begin : g_cnt_w_check
    $error("key_conditioner: CNT_W too small for the configured counts");
  end

  logic [N_KEYS-1:0] sync1_q, sync2_q, s;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= kif.key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef KEY_AUTO_REPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .s       (s[i]),
      .level_o (kif.key_level[i]),
      .press_o (kif.key_press[i]),
      .rel_o   (kif.key_release[i]),
      .rpt_o   (kif.key_repeat[i])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus randomized key activity,
// checked every cycle against a run-length reference model.
module tb_key_conditioner;
  localparam int NK = 3;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: level flips after D consecutive cycles of disagreement;
  // while held, a repeat fires RD cycles after the press (or after a release
  // bounce), then every RP cycles.
  logic [NK-1:0] m_lvl, m_press, m_rel, m_rpt, m_s1, m_s2, m_rmode;
  int m_run [NK];
  int m_age [NK];

  // Phase recorders (observed from the DUT).
  int cyc, first_press, first_rel, first_rpt, n_press, n_rel, n_rpt;
  logic [NK-1:0] press_val, rel_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    m_s1 = '0; m_s2 = '0; m_rmode = '0;
    for (int c = 0; c < NK; c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NK-1:0] kn);
    for (int c = 0; c < NK; c++) begin
      m_press[c] = 1'b0; m_rel[c] = 1'b0; m_rpt[c] = 1'b0;
      if (m_s2[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c] = m_s2[c];
          m_run[c] = 0;
          if (m_s2[c]) begin
            m_press[c] = 1'b1; m_age[c] = 0; m_rmode[c] = 1'b0;
          end else begin
            m_rel[c] = 1'b1;
          end
        end
      end else begin
        if (m_lvl[c]) begin
          if (m_run[c] > 0) begin
            m_age[c] = 0; m_rmode[c] = 1'b0;
          end else if (REP_EN) begin
            m_age[c]++;
            if (m_age[c] == (m_rmode[c] ? RP : RD)) begin
              m_rpt[c] = 1'b1; m_age[c] = 0; m_rmode[c] = 1'b1;
            end
          end
        end
        m_run[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = ~kn;
  endtask

  task automatic clr_rec();
    cyc = 0; first_press = -1; first_rel = -1; first_rpt = -1;
    n_press = 0; n_rel = 0; n_rpt = 0; press_val = '0; rel_val = '0;
  endtask

  // One clock: drive keys, advance model at the edge, compare at the negedge.
  task automatic step(input logic [NK-1:0] kn);
    kif.key_n = kn;
    @(posedge clk);
    model_step(kn);
    cyc++;
    @(negedge clk);
    chk("outs", {kif.key_level, kif.key_press, kif.key_release, kif.key_repeat},
                {m_lvl, m_press, m_rel, m_rpt});
    if (kif.key_press != '0) begin
      n_press++;
      if (first_press < 0) begin first_press = cyc; press_val = kif.key_press; end
    end
    if (kif.key_release != '0) begin
      n_rel++;
      if (first_rel < 0) begin first_rel = cyc; rel_val = kif.key_release; end
    end
    if (kif.key_repeat != '0) begin
      n_rpt++;
      if (first_rpt < 0) first_rpt = cyc;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_outs", {kif.key_level, kif.key_press, kif.key_release, kif.key_repeat}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int hold_left [NK];
  logic [NK-1:0] kn_r;

  initial begin
    // Reset with every key pressed.
    kif.key_n = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outs_hold", {kif.key_level, kif.key_press, kif.key_release, kif.key_repeat}, 32'd0);
    rst = 1'b1;
    clr_rec();
    repeat (10) step(3'b000);
    chk("rst_press_lat", first_press, 6);
    chk("rst_press_val", press_val, 3'b111);
    chk("rst_level", kif.key_level, 3'b111);
    clr_rec();
    repeat (10) step(3'b111);
    chk("all_rel_lat", first_rel, 6);
    chk("all_level_off", kif.key_level, 3'b000);

    // Bounce rejection on key 0: never D stable cycles.
    clr_rec();
    repeat (2) step(3'b110);
    step(3'b111);
    repeat (3) step(3'b110);
    repeat (8) step(3'b111);
    chk("bounce_no_press", n_press, 0);
    chk("bounce_level", kif.key_level, 3'b000);

    // Clean press/release on key 1.
    clr_rec();
    repeat (30) step(3'b101);
    repeat (12) step(3'b111);
    chk("clean_press_lat", first_press, 6);
    chk("clean_press_cnt", n_press, 1);
    chk("clean_rel_lat", first_rel, 36);
    chk("clean_rel_cnt", n_rel, 1);

    // Auto-repeat on key 0, held 60 cycles.
    clr_rec();
    repeat (60) step(3'b110);
    repeat (10) step(3'b111);
    chk("rpt_first", first_rpt, REP_EN ? 26 : -1);
    chk("rpt_count", n_rpt, REP_EN ? 8 : 0);

    // Independence: keys 0 and 2 together, then release only key 2.
    clr_rec();
    repeat (10) step(3'b010);
    chk("indep_press_val", press_val, 3'b101);
    chk("indep_press_cnt", n_press, 1);
    repeat (10) step(3'b110);
    chk("indep_rel_val", rel_val, 3'b100);
    chk("indep_level0", kif.key_level, 3'b001);
    repeat (10) step(3'b111);

    // Reset while key 2 is held long enough to be repeating.
    repeat (30) step(3'b011);
    pulse_reset();
    clr_rec();
    repeat (10) step(3'b011);
    chk("midrst_press_lat", first_press, 6);
    chk("midrst_level", kif.key_level, 3'b100);
    repeat (10) step(3'b111);

    // Random holds and bounces on all keys.
    kn_r = '1;
    for (int c = 0; c < NK; c++) hold_left[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NK; c++) begin
        if (hold_left[c] == 0) begin
          kn_r[c] = ~kn_r[c];
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 45));
        end
        hold_left[c]--;
      end
      step(kn_r);
    end
    repeat (10) step(3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
